// File: rtl/vga_text_console.sv
// Text console front end: accepts a byte stream, interprets control codes, owns
// the 4096x8 character RAM and serves the scanner's read port every cycle.
module vga_text_console #(
    parameter int unsigned COLS      = 100,
    parameter int unsigned ROWS      = 32,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        busy,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    input  logic        rd_req,
    input  logic [11:0] rd_addr,
    output logic [7:0]  rd_ascii,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_CLR_ALL  = 2'd0,
        ST_IDLE     = 2'd1,
        ST_SCROLL   = 2'd2,
        ST_CLR_LINE = 2'd3
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    // Handshake: a byte moves on every rising clk edge where wr_valid && wr_ready.
    logic [7:0]  mem [0:4095];

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [11:0] clr_addr_q, clr_addr_d;
    logic [6:0]  scol_q, scol_d;
    logic [4:0]  srow_q, srow_d;
    logic        rd_done_q, rd_done_d;
    logic        pend_q, pend_d;
    logic [11:0] pend_addr_q, pend_addr_d;
    logic [7:0]  rd_ascii_q;
    logic [7:0]  scroll_rdata;

    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic [11:0] scroll_raddr;
    logic [7:0]  tab_col;
    logic        do_nl;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        clr_addr_d   = clr_addr_q;
        scol_d       = scol_q;
        srow_d       = srow_q;
        rd_done_d    = rd_done_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        mem_we       = 1'b0;
        mem_waddr    = clr_addr_q;
        mem_wdata    = FILL_CHAR;
        scroll_raddr = {srow_q, scol_q};
        tab_col      = ({1'b0, col_q} | 8'd7) + 8'd1;
        do_nl        = 1'b0;

        case (state_q)
            ST_CLR_ALL: begin
                mem_we     = 1'b1;
                clr_addr_d = clr_addr_q + 12'd1;
                if (clr_addr_q == 12'hFFF) begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_IDLE: begin
                if (wr_valid) begin
                    if (wr_data >= 8'h20 && wr_data != 8'h7F) begin
                        mem_we    = 1'b1;
                        mem_waddr = {row_q, col_q};
                        mem_wdata = wr_data;
                        if (col_q == LAST_COL) do_nl = 1'b1;
                        else                   col_d = col_q + 7'd1;
                    end else begin
                        case (wr_data)
                            8'h0A: do_nl = 1'b1;
                            8'h0D: col_d = '0;
                            8'h08: begin
                                if (col_q != '0) begin
                                    col_d     = col_q - 7'd1;
                                    mem_we    = 1'b1;
                                    mem_waddr = {row_q, col_q - 7'd1};
                                end
                            end
                            8'h09: begin
                                if (tab_col >= 8'(COLS)) do_nl = 1'b1;
                                else                     col_d = tab_col[6:0];
                            end
                            8'h0C: begin
                                state_d    = ST_CLR_ALL;
                                clr_addr_d = '0;
                            end
                            default: ;
                        endcase
                    end
                    if (do_nl) begin
                        col_d = '0;
                        if (row_q < LAST_ROW) begin
                            row_d = row_q + 5'd1;
                        end else begin
                            state_d   = ST_SCROLL;
                            scol_d    = '0;
                            srow_d    = 5'd1;
                            rd_done_d = (ROWS == 1);
                            pend_d    = 1'b0;
                        end
                    end
                end
            end
            ST_SCROLL: begin
                // Two-stage copy: the cell read this cycle is written one row up next cycle.
                mem_we    = pend_q;
                mem_waddr = pend_addr_q;
                mem_wdata = scroll_rdata;
                if (!rd_done_q) begin
                    pend_d      = 1'b1;
                    pend_addr_d = {srow_q - 5'd1, scol_q};
                    if (scol_q == LAST_COL) begin
                        scol_d = '0;
                        if (srow_q == LAST_ROW) rd_done_d = 1'b1;
                        else                    srow_d    = srow_q + 5'd1;
                    end else begin
                        scol_d = scol_q + 7'd1;
                    end
                end else begin
                    pend_d  = 1'b0;
                    scol_d  = '0;
                    state_d = ST_CLR_LINE;
                end
            end
            ST_CLR_LINE: begin
                mem_we    = 1'b1;
                mem_waddr = {LAST_ROW, scol_q};
                if (scol_q == LAST_COL) state_d = ST_IDLE;
                else                    scol_d  = scol_q + 7'd1;
            end
            default: state_d = ST_CLR_ALL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLR_ALL;
            col_q       <= '0;
            row_q       <= '0;
            clr_addr_q  <= '0;
            scol_q      <= '0;
            srow_q      <= '0;
            rd_done_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            clr_addr_q  <= clr_addr_d;
            scol_q      <= scol_d;
            srow_q      <= srow_d;
            rd_done_q   <= rd_done_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        scroll_rdata <= mem[scroll_raddr];
    end

    // Display port never waits on the FSM; a colliding write shows up on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_ascii_q <= '0;
        else if (rd_req) rd_ascii_q <= mem[rd_addr];
    end

    assign wr_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign cur_col   = col_q;
    assign cur_row   = row_q;
    assign rd_ascii  = rd_ascii_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console: clear timing, printing, wrap, control
// codes, scroll contents/timing and reset abort during a scroll.
module tb_vga_text_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_ready;
  logic        busy;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        rd_req = 1'b0;
  logic [11:0] rd_addr = 12'h000;
  logic [7:0]  rd_ascii;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  vga_text_console dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .cur_col(cur_col), .cur_row(cur_row),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ascii(rd_ascii),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    while (!wr_ready && n < 10000) begin
      tick();
      n++;
    end
    if (!wr_ready) check("hs_timeout", {31'b0, wr_ready}, 32'd1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_cell(input logic [11:0] a, output logic [7:0] d);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    d = rd_ascii;
    rd_req = 1'b0;
  endtask

  // Counts cycles until busy drops; flags cursor movement or wr_ready while busy.
  task automatic wait_not_busy(input logic [6:0] ec, input logic [4:0] er,
                               output int n, output int bad);
    n = 0;
    bad = 0;
    while (busy && n < 10000) begin
      if (wr_ready || cur_col != ec || cur_row != er) bad++;
      tick();
      n++;
    end
    if (busy) check("busy_timeout", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int n, bad;
    logic [7:0] d;
    logic [7:0] e;

    // Reset values while rst_n is low
    #2;
    check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_col", {25'b0, cur_col}, 32'd0);
    check("rst_row", {27'b0, cur_row}, 32'd0);
    check("rst_rd_ascii", {24'b0, rd_ascii}, 32'd0);
    tick();
    rst_n = 1'b1;

    wait_not_busy(7'd0, 5'd0, n, bad);
    check("clr_all_cycles", n, 32'd4096);
    check("clr_all_stable", bad, 32'd0);

    // Pipelined sweep of every address with rd_req held high
    bad = 0;
    rd_req  = 1'b1;
    rd_addr = 12'h000;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (rd_ascii !== 8'h20) bad++;
      rd_addr = rd_addr + 12'd1;
    end
    rd_req = 1'b0;
    check("sweep_fill", bad, 32'd0);

    // "AB", CR, "C"
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h0D);
    send_byte(8'h43);
    check("abc_col", {25'b0, cur_col}, 32'd1);
    check("abc_row", {27'b0, cur_row}, 32'd0);
    read_cell(12'h000, d);
    check("abc_cell0", {24'b0, d}, 32'h43);
    read_cell(12'h001, d);
    check("abc_cell1", {24'b0, d}, 32'h42);
    tick();
    check("rd_hold", {24'b0, rd_ascii}, 32'h42);

    // 100 'x' fill row 0 and wrap
    send_byte(8'h0D);
    for (int i = 0; i < 100; i++) send_byte(8'h78);
    check("wrap_col", {25'b0, cur_col}, 32'd0);
    check("wrap_row", {27'b0, cur_row}, 32'd1);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      read_cell(12'(c), d);
      if (d !== 8'h78) bad++;
    end
    check("row0_x", bad, 32'd0);
    read_cell(12'h064, d);
    check("col100_untouched", {24'b0, d}, 32'h20);

    // TAB / BS / ignored codes
    send_byte(8'h09);
    check("tab_from0", {25'b0, cur_col}, 32'd8);
    for (int i = 0; i < 11; i++) send_byte(8'h09);
    check("tab_to96", {25'b0, cur_col}, 32'd96);
    send_byte(8'h09);
    check("tab_wrap_col", {25'b0, cur_col}, 32'd0);
    check("tab_wrap_row", {27'b0, cur_row}, 32'd2);
    send_byte(8'h08);
    check("bs_col0_col", {25'b0, cur_col}, 32'd0);
    check("bs_col0_row", {27'b0, cur_row}, 32'd2);
    send_byte(8'h51);
    read_cell(12'h100, d);
    check("q_cell", {24'b0, d}, 32'h51);
    check("q_col", {25'b0, cur_col}, 32'd1);
    send_byte(8'h08);
    check("bs_col", {25'b0, cur_col}, 32'd0);
    read_cell(12'h100, d);
    check("bs_cell", {24'b0, d}, 32'h20);
    send_byte(8'h7F);
    send_byte(8'h01);
    check("ign_col", {25'b0, cur_col}, 32'd0);
    check("ign_row", {27'b0, cur_row}, 32'd2);
    read_cell(12'h100, d);
    check("ign_cell", {24'b0, d}, 32'h20);

    // Form feed: full clear, cursor held then homed
    send_byte(8'h0C);
    check("ff_busy", {31'b0, busy}, 32'd1);
    wait_not_busy(7'd0, 5'd2, n, bad);
    check("ff_cycles", n, 32'd4096);
    check("ff_stable", bad, 32'd0);
    check("ff_home_row", {27'b0, cur_row}, 32'd0);
    read_cell(12'h000, d);
    check("ff_cell0", {24'b0, d}, 32'h20);

    // Rows 0..31 get 99 copies of '0'+row; LF on row 31 scrolls
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 99; c++) send_byte(8'(8'h30 + r));
      if (r < 31) send_byte(8'h0A);
    end
    check("pre_scroll_row", {27'b0, cur_row}, 32'd31);
    send_byte(8'h0A);
    wait_not_busy(7'd0, 5'd31, n, bad);
    check("scroll_cycles", n, 32'd3201);
    check("scroll_stable", bad, 32'd0);
    check("scroll_col", {25'b0, cur_col}, 32'd0);
    check("scroll_row", {27'b0, cur_row}, 32'd31);
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 100; c++) begin
        e = (r < 31 && c < 99) ? 8'(8'h31 + r) : 8'h20;
        read_cell({5'(r), 7'(c)}, d);
        if (d !== e) bad++;
      end
    end
    check("scroll_contents", bad, 32'd0);
    read_cell(12'h000, d);
    check("scroll_r0", {24'b0, d}, 32'h31);
    read_cell({5'd30, 7'd0}, d);
    check("scroll_r30", {24'b0, d}, 32'h4F);
    read_cell({5'd31, 7'd50}, d);
    check("scroll_r31", {24'b0, d}, 32'h20);

    // Reset in the middle of a scroll, with a byte held pending
    send_byte(8'h0A);
    repeat (500) tick();
    check("mid_scroll_busy", {31'b0, busy}, 32'd1);
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    rst_n = 1'b0;
    #1;
    check("abort_wr_ready", {31'b0, wr_ready}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd1);
    check("abort_row", {27'b0, cur_row}, 32'd0);
    check("abort_rd_ascii", {24'b0, rd_ascii}, 32'd0);
    tick();
    rst_n = 1'b1;
    wait_not_busy(7'd0, 5'd0, n, bad);
    check("abort_clr_cycles", n, 32'd4096);
    check("abort_clr_stable", bad, 32'd0);
    tick();
    wr_valid = 1'b0;
    check("held_once_col", {25'b0, cur_col}, 32'd1);
    read_cell(12'h000, d);
    check("held_cell0", {24'b0, d}, 32'h5A);
    read_cell(12'h001, d);
    check("held_cell1", {24'b0, d}, 32'h20);
    read_cell({5'd5, 7'd3}, d);
    check("abort_cleared", {24'b0, d}, 32'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
